// File: rtl/gps_pkg.sv
// Shared GPS/NMEA definitions: receiver FSM states, error codes and framing characters.
package gps_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBody,
        StCsHi,
        StCsLo,
        StEolCr,
        StEolLf
    } nmea_state_e;

    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrChecksum = 3'd1;
    localparam logic [2:0] ErrHex      = 3'd2;
    localparam logic [2:0] ErrEol      = 3'd3;
    localparam logic [2:0] ErrOverflow = 3'd4;
    localparam logic [2:0] ErrRestart  = 3'd5;
    localparam logic [2:0] ErrIdLong   = 3'd6;

    localparam logic [7:0] AsciiDollar = 8'h24;
    localparam logic [7:0] AsciiComma  = 8'h2C;
    localparam logic [7:0] AsciiStar   = 8'h2A;
    localparam logic [7:0] AsciiCr     = 8'h0D;
    localparam logic [7:0] AsciiLf     = 8'h0A;

    localparam int unsigned NMEA_MAX_LEN = 82;

endpackage

// File: rtl/nmea_hex_nibble.sv
// Uppercase ASCII hex digit to 4-bit value; hex_ok flags a legal digit.
module nmea_hex_nibble (
    input  logic [7:0] ascii,
    output logic [3:0] value,
    output logic       hex_ok
);

    always_comb begin
        value  = 4'd0;
        hex_ok = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            value  = ascii[3:0];
            hex_ok = 1'b1;
        end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
            // 'A'..'F' have low nibble 1..6
            value  = ascii[3:0] + 4'd9;
            hex_ok = 1'b1;
        end
    end

endmodule

// File: rtl/nmea_sentence_rx.sv
// NMEA sentence framer: checks $body*HH<CR><LF>, streams tagged payload, reports status.
module nmea_sentence_rx
    import gps_pkg::*;
#(
    parameter int unsigned MAX_LEN = NMEA_MAX_LEN,
    parameter int unsigned ID_MAX  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            pay_data,
    output logic                  pay_valid,
    output logic [4:0]            pay_field,
    output logic [6:0]            pay_char,
    output logic [ID_MAX*8-1:0]   msg_id,
    output logic                  msg_done,
    output logic                  msg_ok,
    output logic [2:0]            msg_err
);

    localparam int unsigned LenW = $clog2(MAX_LEN + 1);
    localparam logic [LenW-1:0] MaxLenV = LenW'(MAX_LEN);
    localparam logic [6:0]      IdMaxV  = 7'(ID_MAX);

    nmea_state_e      state;
    logic [7:0]       csum;
    logic [7:0]       cs_rx;
    logic [LenW-1:0]  len;
    logic [4:0]       field;
    logic [6:0]       char_idx;

    logic [3:0]       nib;
    logic             nib_ok;

    nmea_hex_nibble u_hex (
        .ascii  (rx_data),
        .value  (nib),
        .hex_ok (nib_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            csum      <= 8'd0;
            cs_rx     <= 8'd0;
            len       <= '0;
            field     <= 5'd0;
            char_idx  <= 7'd0;
            pay_data  <= 8'd0;
            pay_valid <= 1'b0;
            pay_field <= 5'd0;
            pay_char  <= 7'd0;
            msg_id    <= '0;
            msg_done  <= 1'b0;
            msg_ok    <= 1'b0;
            msg_err   <= ErrNone;
        end else begin
            pay_valid <= 1'b0;
            msg_done  <= 1'b0;
            msg_ok    <= 1'b0;
            msg_err   <= ErrNone;
            if (rx_valid) begin
                if (rx_data == AsciiDollar) begin
                    // A '$' always opens a fresh sentence, aborting any in flight
                    if (state != StIdle) begin
                        msg_done <= 1'b1;
                        msg_err  <= ErrRestart;
                    end
                    csum     <= 8'd0;
                    field    <= 5'd0;
                    char_idx <= 7'd0;
                    len      <= LenW'(1);
                    msg_id   <= '0;
                    state    <= StBody;
                end else if (state != StIdle) begin
                    if (len == MaxLenV) begin
                        msg_done <= 1'b1;
                        msg_err  <= ErrOverflow;
                        state    <= StIdle;
                    end else begin
                        len <= len + LenW'(1);
                        case (state)
                            StBody: begin
                                if (rx_data == AsciiStar) begin
                                    state <= StCsHi;
                                end else if (rx_data == AsciiComma) begin
                                    csum     <= csum ^ rx_data;
                                    char_idx <= 7'd0;
                                    if (field != 5'd31) field <= field + 5'd1;
                                end else if (field == 5'd0 && char_idx == IdMaxV) begin
                                    msg_done <= 1'b1;
                                    msg_err  <= ErrIdLong;
                                    state    <= StIdle;
                                end else begin
                                    csum      <= csum ^ rx_data;
                                    pay_valid <= 1'b1;
                                    pay_data  <= rx_data;
                                    pay_field <= field;
                                    pay_char  <= char_idx;
                                    if (char_idx != 7'd127) char_idx <= char_idx + 7'd1;
                                    if (field == 5'd0) begin
                                        msg_id <= {msg_id[ID_MAX*8-9:0], rx_data};
                                    end
                                end
                            end
                            StCsHi, StCsLo: begin
                                if (nib_ok) begin
                                    if (state == StCsHi) begin
                                        cs_rx[7:4] <= nib;
                                        state      <= StCsLo;
                                    end else begin
                                        cs_rx[3:0] <= nib;
                                        state      <= StEolCr;
                                    end
                                end else begin
                                    msg_done <= 1'b1;
                                    msg_err  <= ErrHex;
                                    state    <= StIdle;
                                end
                            end
                            StEolCr: begin
                                if (rx_data == AsciiCr) begin
                                    state <= StEolLf;
                                end else begin
                                    msg_done <= 1'b1;
                                    msg_err  <= ErrEol;
                                    state    <= StIdle;
                                end
                            end
                            StEolLf: begin
                                msg_done <= 1'b1;
                                state    <= StIdle;
                                if (rx_data != AsciiLf) begin
                                    msg_err <= ErrEol;
                                end else if (cs_rx == csum) begin
                                    msg_ok <= 1'b1;
                                end else begin
                                    msg_err <= ErrChecksum;
                                end
                            end
                            default: state <= StIdle;
                        endcase
                    end
                end
            end
        end
    end

endmodule
